multadd_result_fifo: RTL and testbench
======================================

Name: multadd_result_fifo

Overview:
- Downstream stage of the two-stage multiply-add pipeline.
- Captures each 17-bit product-sum on the single-cycle prodout strobe and buffers it in a small FIFO.
- Hands results to the consumer over a valid/ready handshake.
- The multadd has no backpressure, so this block absorbs consumer stalls and flags any results it drops.

Parameters:
- DEPTH, 8, number of FIFO entries; power of 2, minimum 2.
- PROD_W, 17, result width; must match the multadd prodsum width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- prodsum  input  PROD_W  result from the multadd
- prodout  input  1  one-cycle strobe; prodsum is valid in the same cycle
- out_data  output  PROD_W  head-of-FIFO result
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts out_data this cycle
- count  output  $clog2(DEPTH)+1  current occupancy
- full  output  1  count == DEPTH
- overflow  output  1  sticky: a strobe was dropped
- ovf_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset is asynchronous and active-high; the interface uses one clock (clk) and reset rst.
- Reset values: out_valid=0, out_data=0, count=0, full=0, overflow=0. Read/write pointers are 0. Contents are discarded.
- Reset may assert mid-operation. All state clears immediately. The first strobe after deassertion is stored at entry 0.
- Pointers are $clog2(DEPTH)+1 bits wide. The MSB distinguishes full from empty. Pointers wrap naturally modulo 2*DEPTH.
- Push: push = prodout && (!full || pop). prodsum is written at mem[wr_ptr] and wr_ptr increments.
- Pop: pop = out_valid && out_ready. rd_ptr increments.
- The FIFO is first-word fall-through:
  - out_data = mem[rd_ptr] while out_valid=1; otherwise out_data=0.
  - A result pushed at edge N appears on out_data and out_valid in the cycle after edge N (1-cycle latency when empty).
- count updates on each edge: +1 for push only, -1 for pop only, unchanged for both or neither.
- Simultaneous push and pop when full: both occur, count stays DEPTH, and nothing is dropped.
- Simultaneous push and pop when empty: only the push occurs, because out_valid=0 prevents the pop.
- Drop: prodout=1, full=1, pop=0. The data is discarded and overflow is set at the next edge.
- overflow stays set until ovf_clr=1. If a drop and ovf_clr occur in the same cycle, set wins.
- out_ready while empty has no effect.
- Value rules:
  - prodsum is stored unmodified.
  - X on prodsum while prodout=0 is ignored.
  - out_data must be stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: MULTADD_RESULT_ACCUM_EN.
- With the macro defined:
  - Adds output acc_sum [ACC_W-1:0] (ACC_W=24, from the package) and input acc_clr.
  - acc_sum adds every pushed prodsum (dropped values are excluded).
  - acc_sum saturates at 2^ACC_W-1 instead of wrapping.
  - acc_clr has priority over an accumulate in the same cycle and loads the pushed value. If no push occurs that cycle, acc_sum loads 0.
  - acc_sum resets to 0.
- Without the macro: acc_sum and acc_clr are absent and no accumulator logic is built.

Decomposition:
- multadd_pkg holds:
  - PROD_W=17
  - ACC_W=24
  - typedef prod_t = logic [PROD_W-1:0]
  - typedef acc_t = logic [ACC_W-1:0]
- Sub-module multadd_result_fifo_mem:
  - DEPTH×PROD_W storage.
  - Synchronous write port, asynchronous read port.
  - No reset on the array.
- The top level holds pointers, count, flags, handshake and the optional accumulator.

Test Plan:
- Single strobe 0x1_0001 with out_ready=0 → out_valid=1 the next cycle, out_data=0x10001, count=1. Then pulse out_ready for 1 cycle → count=0, out_valid=0.
- 8 strobes 1..8 with out_ready=0 → full=1, count=8. A 9th strobe (value 9) → overflow=1 and count stays 8. Then drain → outputs 1..8 in order; 9 never appears.
- Full FIFO, strobe 0x1FFFF with out_ready=1 in the same cycle → no overflow, count=8, and 0x1FFFF emerges last after draining.
- 20 strobes interleaved with random out_ready → output order matches input, pointer wrap is exercised, no drop while count<8.
- Fill to count=5, assert rst asynchronously mid-cycle → all outputs are 0 immediately. A strobe 0x0_00AA after release → out_data=0xAA, count=1.
- MULTADD_RESULT_ACCUM_EN: push 0x1FFFF 130 times with draining → acc_sum saturates at 0xFFFFFF. Then acc_clr together with a push of 5 → acc_sum=5.

Source files
------------

// File: rtl/multadd_pkg.sv
// Shared types and widths for the multiply-add pipeline and its result FIFO.
package multadd_pkg;

   localparam int PROD_W = 17;
   localparam int ACC_W  = 24;

   typedef logic [PROD_W-1:0] prod_t;
   typedef logic [ACC_W-1:0]  acc_t;

   // Add a product-sum to the running total, clamping at the all-ones value
   // instead of wrapping.
   function automatic acc_t acc_sat_add(input acc_t acc, input prod_t val);
      logic [ACC_W:0] sum;
      sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, val};
      return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
   endfunction

endpackage : multadd_pkg

// File: rtl/multadd_result_fifo_mem.sv
// Storage array for the result FIFO: synchronous write, asynchronous read.
module multadd_result_fifo_mem #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 17
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write the addressed entry on a push.
   // NOTE: the array has no reset; an entry is only ever read after it has
   // been written, and leaving it unreset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Head entry is visible combinationally for first-word fall-through.
   assign rdata = mem[raddr];

endmodule : multadd_result_fifo_mem

// File: rtl/multadd_result_fifo.sv
// Result buffer behind the multiply-add pipeline. Captures each prodsum on the
// prodout strobe, hands results out over valid/ready and flags dropped results.
// Optional accumulator enabled by defining MULTADD_RESULT_ACCUM_EN.
module multadd_result_fifo
   import multadd_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int PROD_W = multadd_pkg::PROD_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PROD_W-1:0]        prodsum,
   input  logic                     prodout,
   output logic [PROD_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   input  logic                     ovf_clr
`ifdef MULTADD_RESULT_ACCUM_EN
   ,
   input  logic                     acc_clr,
   output logic [ACC_W-1:0]         acc_sum
`endif
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              overflow_q, overflow_d;
   logic [PTR_W-1:0]  occupancy;
   logic [PROD_W-1:0] rd_data;
   logic              push, pop, drop;

   multadd_result_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (PROD_W)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (prodsum),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (rd_data)
   );

   // Status, handshake and push/pop/drop decisions.
   // NOTE: every output of this block gets a value on every path; a missed
   // branch would otherwise infer a latch.
   always_comb begin
      occupancy = wr_ptr_q - rd_ptr_q;
      full      = (occupancy == PTR_W'(DEPTH));
      out_valid = (occupancy != '0);
      pop       = out_valid && out_ready;
      push      = prodout && (!full || pop);
      drop      = prodout && full && !pop;
      out_data  = out_valid ? rd_data : '0;
      count     = occupancy;
      overflow  = overflow_q;
   end

   // Next-state for pointers and the sticky overflow flag (set beats clear).
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (drop) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   // State registers.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef MULTADD_RESULT_ACCUM_EN
   acc_t acc_q, acc_d;

   // Saturating sum of accepted results; a clear reloads with this cycle's push.
   always_comb begin
      acc_d = acc_q;
      if (acc_clr) begin
         acc_d = push ? {{(ACC_W - PROD_W){1'b0}}, prodsum} : '0;
      end else if (push) begin
         acc_d = acc_sat_add(acc_q, prodsum);
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_sum = acc_q;
`endif

endmodule : multadd_result_fifo

// File: tb/tb_multadd_result_fifo.sv
// Self-checking bench for multadd_result_fifo: a directed vector table plus
// hand-written sequences for full/simultaneous, wrap, reset and accumulator.
module tb_multadd_result_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] prodsum;
   logic        prodout;
   logic [16:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  count;
   logic        full;
   logic        overflow;
   logic        ovf_clr;
`ifdef MULTADD_RESULT_ACCUM_EN
   logic        acc_clr;
   logic [23:0] acc_sum;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   multadd_result_fifo #(.DEPTH(8), .PROD_W(17)) dut (
      .clk       (clk),
      .rst       (rst),
      .prodsum   (prodsum),
      .prodout   (prodout),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .full      (full),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
`ifdef MULTADD_RESULT_ACCUM_EN
      ,
      .acc_clr   (acc_clr),
      .acc_sum   (acc_sum)
`endif
   );

   typedef struct {
      logic        prodout;
      logic [16:0] prodsum;
      logic        rdy;
      logic        clr;
      logic        e_valid;
      logic [16:0] e_data;
      logic [3:0]  e_count;
      logic        e_full;
      logic        e_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic po, input logic [16:0] ps, input logic rdy, input logic clr,
                          input logic ev, input logic [16:0] ed, input logic [3:0] ec,
                          input logic ef, input logic eo);
      vec_t v;
      v.prodout = po; v.prodsum = ps; v.rdy = rdy; v.clr = clr;
      v.e_valid = ev; v.e_data = ed; v.e_count = ec; v.e_full = ef; v.e_ovf = eo;
      vecs.push_back(v);
   endtask

   // One clock: drive at the falling edge, sample 1 time unit after the rise.
   task automatic cyc(input logic po, input logic [16:0] ps, input logic rdy, input logic clr);
      @(negedge clk);
      prodout = po; prodsum = ps; out_ready = rdy; ovf_clr = clr;
      @(posedge clk);
      #1;
      @(negedge clk);
      prodout = 1'b0; prodsum = 'x; out_ready = 1'b0; ovf_clr = 1'b0;
   endtask

   task automatic check_state(input string tag, input logic ev, input logic [16:0] ed,
                              input logic [3:0] ec, input logic ef, input logic eo);
      check({tag, " out_valid"}, 32'(out_valid), 32'(ev));
      check({tag, " out_data"},  32'(out_data),  32'(ed));
      check({tag, " count"},     32'(count),     32'(ec));
      check({tag, " full"},      32'(full),      32'(ef));
      check({tag, " overflow"},  32'(overflow),  32'(eo));
   endtask

   initial begin
      logic [16:0] mq[$];
      logic [16:0] exp_list[$];
      logic        m_ovf;
      int          sent;
      int          cycles;
      logic        po, rdy, mpop, mpush;

      rst = 1'b1; prodout = 1'b0; prodsum = '0; out_ready = 1'b0; ovf_clr = 1'b0;
`ifdef MULTADD_RESULT_ACCUM_EN
      acc_clr = 1'b0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_state("reset", 1'b0, 17'h0, 4'd0, 1'b0, 1'b0);
`ifdef MULTADD_RESULT_ACCUM_EN
      check("reset acc_sum", 32'(acc_sum), 32'h0);
`endif

      // ---------------- vector table ----------------
      add_vec(1, 17'h10001, 0, 0,  1, 17'h10001, 1, 0, 0);
      add_vec(0, 17'h0,     1, 0,  0, 17'h0,     0, 0, 0);
      add_vec(0, 17'h0,     1, 0,  0, 17'h0,     0, 0, 0);  // ready while empty
      for (int i = 1; i <= 8; i++)
         add_vec(1, 17'(i), 0, 0,  1, 17'h1, 4'(i), (i == 8), 0);
      add_vec(1, 17'h9,     0, 0,  1, 17'h1, 8, 1, 1);      // drop sets overflow
      add_vec(1, 17'hA,     0, 1,  1, 17'h1, 8, 1, 1);      // drop + clear: set wins
      add_vec(0, 17'h0,     0, 1,  1, 17'h1, 8, 1, 0);      // clear alone
      for (int k = 1; k <= 8; k++)
         add_vec(0, 17'h0, 1, 0,  (k < 8), (k < 8) ? 17'(k + 1) : 17'h0, 4'(8 - k), 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         prodout = vecs[i].prodout;
         prodsum = vecs[i].prodout ? vecs[i].prodsum : 'x;
         out_ready = vecs[i].rdy;
         ovf_clr = vecs[i].clr;
         @(posedge clk);
         #1;
         check_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                     vecs[i].e_count, vecs[i].e_full, vecs[i].e_ovf);
      end
      @(negedge clk);
      prodout = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;

      // ---------------- full with simultaneous push and pop ----------------
      for (int i = 1; i <= 8; i++) cyc(1, 17'h100 + 17'(i), 0, 0);
      check_state("fill", 1'b1, 17'h101, 4'd8, 1'b1, 1'b0);
      cyc(1, 17'h1FFFF, 1, 0);
      check_state("full push+pop", 1'b1, 17'h102, 4'd8, 1'b1, 1'b0);
      for (int i = 2; i <= 8; i++) exp_list.push_back(17'h100 + 17'(i));
      exp_list.push_back(17'h1FFFF);
      foreach (exp_list[i]) begin
         check($sformatf("drain%0d data", i), 32'(out_data), 32'(exp_list[i]));
         cyc(0, 17'h0, 1, 0);
      end
      check("drain empty valid", 32'(out_valid), 32'h0);
      check("drain empty ovf", 32'(overflow), 32'h0);

      // ---------------- interleaved traffic with wrap ----------------
      m_ovf = 1'b0; sent = 0; cycles = 0;
      while ((sent < 20 || mq.size() != 0) && cycles < 400) begin
         @(negedge clk);
         check("rand valid", 32'(out_valid), 32'(mq.size() != 0));
         check("rand count", 32'(count), 32'(mq.size()));
         if (mq.size() != 0) check("rand data", 32'(out_data), 32'(mq[0]));
         po  = (sent < 20) && ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 1) == 1) || (sent >= 20);
         prodout = po; prodsum = po ? 17'h2000 + 17'(sent) : 'x; out_ready = rdy;
         mpop  = rdy && (mq.size() != 0);
         mpush = po && ((mq.size() < 8) || mpop);
         if (po && !mpush) m_ovf = 1'b1;
         if (mpop) void'(mq.pop_front());
         if (mpush) mq.push_back(17'h2000 + 17'(sent));
         if (po) sent++;
         @(posedge clk);
         #1;
         cycles++;
      end
      check("rand finished in budget", 32'(cycles < 400), 32'h1);
      check("rand overflow", 32'(overflow), 32'(m_ovf));
      @(negedge clk);
      prodout = 1'b0; out_ready = 1'b0;
      if (overflow) cyc(0, 17'h0, 0, 1);

      // ---------------- asynchronous reset mid-operation ----------------
      for (int i = 0; i < 5; i++) cyc(1, 17'h300 + 17'(i), 0, 0);
      check("pre-reset count", 32'(count), 32'd5);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_state("async reset", 1'b0, 17'h0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 17'h000AA, 0, 0);
      check_state("post-reset push", 1'b1, 17'h000AA, 4'd1, 1'b0, 1'b0);
      cyc(0, 17'h0, 1, 0);

`ifdef MULTADD_RESULT_ACCUM_EN
      // ---------------- saturating accumulator ----------------
      @(negedge clk) acc_clr = 1'b1;
      @(posedge clk) #1;
      @(negedge clk) acc_clr = 1'b0;
      check("acc clr no push", 32'(acc_sum), 32'h0);
      for (int i = 0; i < 128; i++) cyc(1, 17'h1FFFF, 1, 0);
      check("acc 128 pushes", 32'(acc_sum), 32'hFFFF80);
      for (int i = 0; i < 2; i++) cyc(1, 17'h1FFFF, 1, 0);
      check("acc saturated", 32'(acc_sum), 32'hFFFFFF);
      @(negedge clk);
      acc_clr = 1'b1; prodout = 1'b1; prodsum = 17'h5; out_ready = 1'b1;
      @(posedge clk) #1;
      @(negedge clk);
      acc_clr = 1'b0; prodout = 1'b0; out_ready = 1'b0;
      check("acc clr with push", 32'(acc_sum), 32'h5);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_multadd_result_fifo
